lfsr_gen: RTL and testbench

//  Parametrised Fibonacci LFSR pseudo-random source. Generalises the fixed 8-bit LFSR:
//   - width and tap mask are parameters
//   - runtime seed load and step enable
//   - zero-seed protection
//   - period measurement for self-check

---
 rtl/lfsr_gen.sv | 88 ++++++++
 tb/tb_lfsr_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with seed load, zero-seed protection and
// period measurement against the loaded seed.
module lfsr_gen #(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(8'h01)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] q,
  output logic             fb_bit,
  output logic [WIDTH-1:0] step_cnt,
  output logic             period_done,
  output logic [WIDTH-1:0] period_len,
  output logic             seed_err
);

  logic [WIDTH-1:0] seed_reg;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] cnt_inc;

  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] seed_reg_nxt;
  logic [WIDTH-1:0] step_cnt_nxt;
  logic             period_done_nxt;
  logic [WIDTH-1:0] period_len_nxt;
  logic             seed_err_nxt;

  // Feedback is the parity of the tapped state bits; it becomes the next LSB.
  assign fb_bit  = ^(q & TAPS);
  assign q_step  = {q[WIDTH-2:0], fb_bit};
  assign cnt_inc = step_cnt + WIDTH'(1);

  // Next-state selection: load beats en; idle cycles hold and clear the pulse.
  always_comb begin
    q_nxt           = q;
    seed_reg_nxt    = seed_reg;
    step_cnt_nxt    = step_cnt;
    period_done_nxt = 1'b0;
    period_len_nxt  = period_len;
    seed_err_nxt    = seed_err;

    if (load) begin
      step_cnt_nxt = '0;
      if (seed == '0) begin
        q_nxt        = DEFAULT_SEED;
        seed_reg_nxt = DEFAULT_SEED;
        seed_err_nxt = 1'b1;
      end else begin
        q_nxt        = seed;
        seed_reg_nxt = seed;
        seed_err_nxt = 1'b0;
      end
    end else if (en) begin
      q_nxt        = q_step;
      step_cnt_nxt = cnt_inc;
      if (q_step == seed_reg) begin
        // Completing a period restarts the step count for the next period.
        period_done_nxt = 1'b1;
        period_len_nxt  = cnt_inc;
        step_cnt_nxt    = '0;
      end
    end
  end

  // State and output registers with asynchronous reset to the default seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q           <= DEFAULT_SEED;
      seed_reg    <= DEFAULT_SEED;
      step_cnt    <= '0;
      period_done <= 1'b0;
      period_len  <= '0;
      seed_err    <= 1'b0;
    end else begin
      q           <= q_nxt;
      seed_reg    <= seed_reg_nxt;
      step_cnt    <= step_cnt_nxt;
      period_done <= period_done_nxt;
      period_len  <= period_len_nxt;
      seed_err    <= seed_err_nxt;
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: 8-bit default instance against a
// behavioural model, plus two 4-bit instances for period measurement.
module tb_lfsr_gen;

  localparam logic [7:0] TAPS8 = 8'hB8;
  localparam logic [3:0] TAPS_A = 4'hC;
  localparam logic [3:0] TAPS_B = 4'hF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       en = 1'b0, load = 1'b0;
  logic [7:0] seed = 8'h00;
  logic [7:0] q, step_cnt, period_len;
  logic       fb_bit, period_done, seed_err;

  logic       en4 = 1'b0;
  logic [3:0] q_a, cnt_a, plen_a, q_b, cnt_b, plen_b;
  logic       fb_a, pd_a, err_a, fb_b, pd_b, err_b;

  int vectors = 0;
  int miscompares = 0;

  // reference model state for the 8-bit instance
  int unsigned m_q, m_seed, m_cnt, m_plen;
  bit          m_pd, m_err;

  always #5 clk = ~clk;

  lfsr_gen dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed(seed),
    .q(q), .fb_bit(fb_bit), .step_cnt(step_cnt), .period_done(period_done),
    .period_len(period_len), .seed_err(seed_err)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(TAPS_A), .DEFAULT_SEED(4'h1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en4), .load(1'b0), .seed(4'h0),
    .q(q_a), .fb_bit(fb_a), .step_cnt(cnt_a), .period_done(pd_a),
    .period_len(plen_a), .seed_err(err_a)
  );

  lfsr_gen #(.WIDTH(4), .TAPS(TAPS_B), .DEFAULT_SEED(4'h1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en4), .load(1'b0), .seed(4'h0),
    .q(q_b), .fb_bit(fb_b), .step_cnt(cnt_b), .period_done(pd_b),
    .period_len(plen_b), .seed_err(err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned parity(input int unsigned v, input int unsigned taps);
    return $countones(v & taps) % 2;
  endfunction

  // Galois-free arithmetic rule: shift left, append parity, keep width bits.
  function automatic int unsigned advance(input int unsigned v, input int unsigned taps,
                                          input int unsigned w);
    return ((v * 2) + parity(v, taps)) % (1 << w);
  endfunction

  task automatic model_reset();
    m_q = 1; m_seed = 1; m_cnt = 0; m_plen = 0; m_pd = 0; m_err = 0;
  endtask

  task automatic model_cycle(input bit e, input bit l, input int unsigned s);
    int unsigned nq;
    if (l) begin
      if (s != 0) begin m_q = s; m_seed = s; m_err = 0; end
      else        begin m_q = 1; m_seed = 1; m_err = 1; end
      m_cnt = 0; m_pd = 0;
    end else if (e) begin
      nq    = advance(m_q, TAPS8, 8);
      m_cnt = (m_cnt + 1) % 256;
      m_pd  = (nq == m_seed);
      if (m_pd) begin m_plen = m_cnt; m_cnt = 0; end
      m_q = nq;
    end else begin
      m_pd = 0;
    end
  endtask

  task automatic check_all();
    check("q", 32'(q), m_q);
    check("fb_bit", 32'(fb_bit), parity(m_q, TAPS8));
    check("step_cnt", 32'(step_cnt), m_cnt);
    check("period_done", 32'(period_done), 32'(m_pd));
    check("period_len", 32'(period_len), m_plen);
    check("seed_err", 32'(seed_err), 32'(m_err));
  endtask

  task automatic cyc(input bit e, input bit l, input logic [7:0] s);
    en = e; load = l; seed = s;
    @(posedge clk);
    #1;
    model_cycle(e, l, s);
    check_all();
  endtask

  initial begin
    logic [7:0] seq1 [5];
    int pulses;
    int unsigned qa, qb, ca, cb, pla, plb;
    seq1[0] = 8'h02; seq1[1] = 8'h04; seq1[2] = 8'h08; seq1[3] = 8'h11; seq1[4] = 8'h23;

    // reset state
    model_reset();
    #12;
    check_all();
    check("a_reset_q", 32'(q_a), 1);
    check("b_reset_plen", 32'(plen_b), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // free run from 01 and compare against the documented sequence
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 8'h00);
      check("seq", 32'(q), 32'(seq1[i]));
    end

    // complete a full period: exactly one pulse, at q==01
    pulses = 0;
    for (int i = 5; i < 255; i++) begin
      cyc(1'b1, 1'b0, 8'h00);
      if (period_done) pulses++;
    end
    check("period_pulses", pulses, 1);
    check("period_q", 32'(q), 32'h01);
    check("period_len255", 32'(period_len), 255);
    check("period_cnt0", 32'(step_cnt), 0);

    // zero seed substitution, then a valid seed
    cyc(1'b0, 1'b1, 8'h00);
    check("zero_seed_err", 32'(seed_err), 1);
    cyc(1'b0, 1'b1, 8'h88);
    check("seed88_q", 32'(q), 32'h88);

    // load beats en; stepping only on en cycles
    cyc(1'b1, 1'b1, 8'hE4);
    check("loadE4_q", 32'(q), 32'hE4);
    for (int i = 0; i < 8; i++) cyc(1'(i % 2 == 0), 1'b0, 8'h00);

    // load on the same edge as a period match: no pulse
    cyc(1'b0, 1'b1, 8'h01);
    for (int i = 0; i < 254; i++) cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b1, 8'h01);
    check("load_vs_match_pd", 32'(period_done), 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [7:0] rs;
      rs = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), rs);
    end

    // asynchronous reset between edges at step 100
    cyc(1'b0, 1'b1, 8'h5A);
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_q", 32'(q), 32'h01);
    check("async_cnt", 32'(step_cnt), 0);
    check("async_plen", 32'(period_len), 0);
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
    en = 1'b0; load = 1'b0;

    // 4-bit instances: maximal (C) and non-maximal (F) taps
    qa = 1; qb = 1; ca = 0; cb = 0; pla = 0; plb = 0;
    en4 = 1'b1;
    for (int i = 0; i < 15; i++) begin
      bit pa, pb;
      @(posedge clk); #1;
      qa = advance(qa, TAPS_A, 4); ca = ca + 1; pa = (qa == 1);
      if (pa) begin pla = ca; ca = 0; end
      qb = advance(qb, TAPS_B, 4); cb = cb + 1; pb = (qb == 1);
      if (pb) begin plb = cb; cb = 0; end
      check("a_q", 32'(q_a), qa);
      check("a_pd", 32'(pd_a), 32'(pa));
      check("b_q", 32'(q_b), qb);
      check("b_pd", 32'(pd_b), 32'(pb));
      check("b_cnt", 32'(cnt_b), cb);
    end
    en4 = 1'b0;
    check("a_period15", 32'(plen_a), 15);
    check("b_period5", 32'(plen_b), 5);
    check("a_model_plen", 32'(plen_a), pla);
    check("b_model_plen", 32'(plen_b), plb);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
